// File: rtl/multiword_add_sequencer_if.sv
// Streaming bus for the multi-word add/subtract sequencer.
// Upstream side: in_valid/in_ready handshake carrying operand words a, b,
// the op select sub (first word only) and in_last.
// Downstream side: out_valid/out_ready handshake carrying result word c,
// out_last and the end-of-operation flags co, ovf, len_err.
// master = the environment that drives operands and accepts results;
// slave  = the sequencer.
interface multiword_add_sequencer_if #(
  parameter int unsigned N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic         out_last;
  logic         co;
  logic         ovf;
  logic         len_err;

  modport master (
    output in_valid, a, b, sub, in_last, out_ready,
    input  in_ready, out_valid, c, out_last, co, ovf, len_err
  );

  modport slave (
    input  in_valid, a, b, sub, in_last, out_ready,
    output in_ready, out_valid, c, out_last, co, ovf, len_err
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Multi-word add/subtract sequencer: adds or subtracts two operands presented
// one N-bit word per transfer, least-significant word first, rippling the
// carry between words. Each accepted word yields one registered result word
// one cycle later. An operation ends on in_last or after W words (len_err).
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave modport of multiword_add_sequencer_if (operand/result streams)
module multiword_add_sequencer #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 4
) (
  input logic                          clk,
  input logic                          rst_n,
  multiword_add_sequencer_if.slave     bus
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic         carry, carry_nxt;
  logic         op_sub, op_sub_nxt;

  logic         in_xfer;
  logic         out_xfer;
  logic         sub_eff;
  logic         cin;
  logic         last_word;
  logic [N-1:0] b_eff;
  logic [N:0]   sum_full;

  logic         out_valid_q;
  logic [N-1:0] c_q;
  logic         out_last_q;
  logic         co_q;
  logic         ovf_q;
  logic         len_err_q;

  // Ready only depends on the output register draining, never on in_valid.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign in_xfer      = bus.in_valid && bus.in_ready;
  assign out_xfer     = out_valid_q && bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.out_last  = out_last_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
  assign bus.len_err   = len_err_q;

  // Sequence state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      op_sub <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      carry  <= carry_nxt;
      op_sub <= op_sub_nxt;
    end
  end

  // Next-state and per-word datapath.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    carry_nxt  = carry;
    op_sub_nxt = op_sub;

    // On a first word the live sub pin selects the op and supplies carry-in
    // (the +1 of two's-complement negation); later words use latched state.
    sub_eff   = (state == IDLE) ? bus.sub : op_sub;
    cin       = (state == IDLE) ? bus.sub : carry;
    b_eff     = sub_eff ? ~bus.b : bus.b;
    sum_full  = {1'b0, bus.a} + {1'b0, b_eff} + (N+1)'(cin);
    // Hitting the word limit forces the operation to close.
    last_word = bus.in_last || (cnt == CNT_MAX);

    if (in_xfer) begin
      carry_nxt  = sum_full[N];
      op_sub_nxt = sub_eff;
      if (last_word) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        state_nxt = BUSY;
        cnt_nxt   = cnt + CW'(1);
      end
    end
  end

  // Result register: loads on every accepted word, holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      out_last_q  <= 1'b0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      len_err_q   <= 1'b0;
    end else if (in_xfer) begin
      out_valid_q <= 1'b1;
      c_q         <= sum_full[N-1:0];
      out_last_q  <= last_word;
      co_q        <= last_word && sum_full[N];
      ovf_q       <= last_word && (bus.a[N-1] == b_eff[N-1])
                               && (sum_full[N-1] != bus.a[N-1]);
      len_err_q   <= last_word && !bus.in_last;
    end else if (out_xfer) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 Parameter N, default 32: word width in bits of each operand/result word.
REQ-002 Parameter W, default 4: maximum words per multi-word operation, W >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk.
REQ-005 in_valid  input  1  operand word pair presented.
REQ-006 in_ready  output  1  block accepts the word pair this cycle.
REQ-007 a  input  N  operand A word, least-significant word first.
REQ-008 b  input  N  operand B word, least-significant word first.
REQ-009 sub  input  1  sampled on the first word only: 0 = A+B, 1 = A-B.
REQ-010 in_last  input  1  marks the final (most-significant) word of the operation.
REQ-011 out_valid  output  1  result word held in output register.
REQ-012 out_ready  input  1  downstream accepts result word.
REQ-013 c  output  N  result word.
REQ-014 out_last  output  1  result word is the final word of the operation.
REQ-015 co  output  1  carry out of the final word; 0 on non-last words.
REQ-016 ovf  output  1  two's-complement signed overflow of the full operation; valid with out_last, 0 otherwise.
REQ-017 len_err  output  1  operation truncated at W words with no in_last; valid with out_last, 0 otherwise.

Function
REQ-018 Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-019 in_ready SHALL be (!out_valid || out_ready); combinational, with no dependency on in_valid.
REQ-020 The block SHALL have two states, IDLE (next accepted word is first word) and BUSY (mid-operation).
REQ-021 IDLE -> BUSY on an accepted word with in_last=0 and word count < W-1; BUSY -> IDLE on an accepted word with in_last=1 or word count = W-1; otherwise hold.
REQ-022 On a first word, op_sub SHALL latch sub; effective carry-in = sub; sub SHALL be ignored on later words.
REQ-023 Datapath per accepted word: {cout, sum} = a + (op_sub ? ~b : b) + cin, N-bit add with carry; cin = carry register on non-first words.
REQ-024 The carry register SHALL load cout on every accepted word.
REQ-025 c, out_last, co, ovf, len_err SHALL be registered; latency input accept to out_valid = 1 cycle.
REQ-026 Output register SHALL load on every input transfer; out_valid SHALL set on input transfer, clear on output transfer without simultaneous input transfer.
REQ-027 Simultaneous output and input transfer in one cycle: new word loads, out_valid stays 1; full throughput of 1 word/cycle.
REQ-028 out_valid && !out_ready: all output fields SHALL hold stable, in_ready=0.
REQ-029 Word counter: 0 on first word, increments per accepted word, returns to 0 on entering IDLE.
REQ-030 Accepted word at count W-1 with in_last=0: treated as last; out_last=1, len_err=1.
REQ-031 ovf on last word = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]), b_eff = op_sub ? ~b : b.
REQ-032 W=1: every word is a complete operation; out_last=1 always; len_err = !in_last.
REQ-033 No output combinational path from a, b, sub, in_last, or in_valid.

Reset
REQ-034 While rst_n=0: state=IDLE, counter=0, carry=0, op_sub=0, out_valid=0, c=0, out_last=0, co=0, ovf=0, len_err=0.
REQ-035 Reset asserted mid-operation SHALL discard the partial operation; first word after release is a first word.
REQ-036 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-037 N=8,W=4: words (A,B) = (FF,01),(FF,00),(00,00) last, sub=0, out_ready=1 -> c=00,00,01; co=0; out_last only on 3rd; 3 consecutive cycles.
REQ-038 N=8,W=2, sub=1: (00,01),(00,00) last -> c=FF,FF, co=0, ovf=0; then (00,00),(80,00) last, sub=1 -> c=00,80, co=1, ovf=0.
REQ-039 N=8,W=1: (7F,01) last -> c=80, ovf=1, co=0; (80,80) last -> c=00, ovf=1, co=1.
REQ-040 N=8,W=2: two words with in_last=0 -> 2nd output out_last=1, len_err=1; next word treated as first word (carry-in = sub).
REQ-041 out_ready held 0 for 3 cycles with out_valid=1 -> in_ready=0, c stable; release -> next word accepted same cycle, no loss or duplication.
REQ-042 rst_n pulsed low after 1st of 3 words -> out_valid=0 immediately; next accepted word uses cin=sub, count restarts at 0.
